muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle sequencer implementing MIPS MULTU/DIVU into the HI/LO registers.
- Has no adder of its own: it drives the shared 32-bit ALU through its ctl/a/b inputs and reads back the ALU result.
- Radix-2 iteration: shift-add for multiply, restoring for divide.
- Sits beside the main ALU in the execute stage. The pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; fixed at 32 for the MIPS datapath.
- ITER_W, 5, width of the iteration counter (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  1  0 = MULTU, 1 = DIVU; sampled with start
- abort  input  1  cancel in-flight operation (pipeline flush)
- a  input  32  multiplicand / dividend
- b  input  32  multiplier / divisor
- alu_out  input  32  result from shared ALU
- alu_ctl  output  4  ALU opcode driven by sequencer
- alu_a  output  32  ALU operand A
- alu_b  output  32  ALU operand B
- hi  output  32  HI result (mult upper word / div remainder)
- lo  output  32  LO result (mult lower word / div quotient)
- busy  output  1  high in RUN state
- done  output  1  one-cycle pulse when hi/lo are valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset applies at any time, including mid-operation.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, count=0, internal operand register=0.

States are IDLE, RUN and DONE.

IDLE:
- On start=1 and abort=0, capture op and b, then initialise:
  - MULTU: hi=0, lo=a.
  - DIVU: hi=0, lo=a.
- If b==0 and op=DIVU: hi=a, lo=32'hFFFFFFFF, go to DONE (done 1 cycle after start).
- Otherwise go to RUN with count=0.

RUN: exactly 32 cycles, count 0..31, then go to DONE. After the count=31 update, done is asserted the next cycle, i.e. 33 cycles after the start edge.

MULTU step:
- alu_ctl=4'b0010 (add), alu_a=hi, alu_b=b_reg.
- sum=alu_out; carry=(sum < hi), an unsigned local compare.
- If lo[0]=1: hi={carry,sum[31:1]}, lo={sum[0],lo[31:1]}.
- Else: hi={1'b0,hi[31:1]}, lo={hi[0],lo[31:1]}.

DIVU step:
- r={hi[30:0],lo[31]}; msb=hi[31].
- alu_ctl=4'b0110 (sub), alu_a=r, alu_b=b_reg.
- If msb=1 or r>=b_reg (unsigned local compare): hi=alu_out, lo={lo[30:0],1'b1}.
- Else: hi=r, lo={lo[30:0],1'b0}.

DONE:
- done=1 for exactly this one cycle, busy=0, then go to IDLE.
- A start in the DONE cycle is ignored.

Other rules:
- Outside RUN: alu_ctl=4'b0010, alu_a=0, alu_b=0. The ALU is free for other users only when busy=0; an external mux selects the owner on busy.
- hi/lo hold their value after done until the next accepted start. In RUN they show intermediate values and are not valid.
- start while busy or in DONE: ignored. No queuing.
- abort=1 in RUN: next state IDLE, done stays 0. hi/lo keep their partial values and are undefined for software.
- abort=1 in IDLE has priority over start (no start). abort in DONE has no effect; done still pulses.
- Async reset mid-RUN: immediate IDLE, all outputs return to reset values, no done pulse.
- All arithmetic is unsigned modulo 2^32. The carry and borrow compares are local 32-bit unsigned compares; the ALU provides only the sum/difference.

Test Plan:
- MULTU a=7, b=6 -> done exactly 33 cycles after start; hi=0, lo=42; busy high for 32 cycles.
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises the carry path).
- DIVU a=100, b=7 -> lo=14, hi=2. DIVU a=32'hFFFFFFFF, b=1 -> lo=32'hFFFFFFFF, hi=0 (exercises the msb path).
- DIVU a=5, b=0 -> done 1 cycle after start, hi=5, lo=32'hFFFFFFFF, busy never asserted.
- MULTU 3*4 started; second start with a=9, b=9 at cycle 10 -> ignored; result hi=0, lo=12. Abort at cycle 15 of a later op -> IDLE, no done pulse.
- rst_n low at cycle 20 of DIVU -> hi=lo=0, busy=0 immediately. After release, a new MULTU 2*3 -> lo=6.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULTU/DIVU sequencer writing HI/LO.
// The block has no adder of its own. Each iteration borrows the shared 32-bit ALU
// through alu_ctl/alu_a/alu_b and reads the result back on alu_out.
// Multiply uses radix-2 shift-add. Divide uses radix-2 restoring division.
module muldiv_seq #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] alu_out,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic       OP_DIVU = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   hi_next, lo_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic               op_reg, op_next;
  logic [ITER_W-1:0]  count, count_next;

  // Per-iteration intermediates.
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [WIDTH-1:0]   rem;
  logic               msb;

  // Outputs are decoded directly from the state, so reset clears them at once.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State and datapath registers. The reset is asynchronous, so it can land mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      b_reg  <= '0;
      op_reg <= 1'b0;
      count  <= '0;
    end else begin
      state  <= state_next;
      hi     <= hi_next;
      lo     <= lo_next;
      b_reg  <= b_next;
      op_reg <= op_next;
      count  <= count_next;
    end
  end

  // Next-state logic, one iteration step, and the drive to the shared ALU.
  always_comb begin
    state_next = state;
    hi_next    = hi;
    lo_next    = lo;
    b_next     = b_reg;
    op_next    = op_reg;
    count_next = count;
    alu_ctl    = ALU_ADD;
    alu_a      = '0;
    alu_b      = '0;
    sum        = alu_out;
    carry      = 1'b0;
    rem        = {hi[WIDTH-2:0], lo[WIDTH-1]};
    msb        = hi[WIDTH-1];

    case (state)
      IDLE: begin
        // abort wins over start, so a flushed instruction never launches.
        if (start && !abort) begin
          op_next    = op;
          b_next     = b;
          hi_next    = '0;
          lo_next    = a;
          count_next = '0;
          if (op == OP_DIVU && b == '0) begin
            // Divide by zero skips the iterations and goes straight to the MIPS-style result.
            hi_next    = a;
            lo_next    = '1;
            state_next = DONE;
          end else begin
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (abort) begin
          // A flush drops the operation. hi/lo keep the partial values.
          state_next = IDLE;
        end else begin
          alu_b = b_reg;
          if (op_reg == OP_DIVU) begin
            alu_ctl = ALU_SUB;
            alu_a   = rem;
            // The 33-bit partial remainder {msb, rem} always covers b_reg when msb is set.
            if (msb || rem >= b_reg) begin
              hi_next = alu_out;
              lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi_next = rem;
              lo_next = {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            alu_ctl = ALU_ADD;
            alu_a   = hi;
            // The ALU returns only the sum, so the carry out comes from a wrap-around compare.
            carry   = (sum < hi);
            if (lo[0]) begin
              hi_next = {carry, sum[WIDTH-1:1]};
              lo_next = {sum[0], lo[WIDTH-1:1]};
            end else begin
              hi_next = {1'b0, hi[WIDTH-1:1]};
              lo_next = {hi[0], lo[WIDTH-1:1]};
            end
          end
          count_next = count + 1'b1;
          if (count == ITER_W'(WIDTH - 1)) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        // This state exists only for the single done cycle. Any start seen here is dropped.
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq, including a model of the shared ALU.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic        abort;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_out;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  muldiv_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .abort  (abort),
    .a      (a),
    .b      (b),
    .alu_out(alu_out),
    .alu_ctl(alu_ctl),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  // Shared ALU model: the 0110 opcode subtracts, and every other opcode adds.
  assign alu_out = (alu_ctl == 4'b0110) ? (alu_a - alu_b) : (alu_a + alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one operation, then wait for done.
  // lat counts cycles from the start cycle, where the cycle that presents start is cycle 0.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat  = 1;
    bcyc = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end
  endtask

  initial begin
    int lat;
    int bcyc;
    int dcount;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; abort = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_alu_ctl", {28'b0, alu_ctl}, 32'h2);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU 7*6.
    run_op(1'b0, 32'd7, 32'd6, lat, bcyc);
    check("mul76_lat", lat, 33);
    check("mul76_busy_cycles", bcyc, 32);
    check("mul76_hi", hi, 32'h0);
    check("mul76_lo", lo, 32'd42);
    @(negedge clk);
    check("mul76_done_pulse", {31'b0, done}, 32'h0);
    check("mul76_lo_hold", lo, 32'd42);
    $display("txn MULTU 7*6 lat=%0d hi=%h lo=%h", lat, hi, lo);

    // MULTU max*max exercises the carry path.
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcyc);
    check("mulmax_hi", hi, 32'hFFFFFFFE);
    check("mulmax_lo", lo, 32'h00000001);
    check("mulmax_alu_a_idle", alu_a, 32'h0);
    $display("txn MULTU ffffffff*ffffffff hi=%h lo=%h", hi, lo);

    // DIVU 100/7.
    run_op(1'b1, 32'd100, 32'd7, lat, bcyc);
    check("div100_lat", lat, 33);
    check("div100_lo", lo, 32'd14);
    check("div100_hi", hi, 32'd2);
    $display("txn DIVU 100/7 hi=%h lo=%h", hi, lo);

    // DIVU max/1 exercises the msb path.
    run_op(1'b1, 32'hFFFFFFFF, 32'd1, lat, bcyc);
    check("divmax_lo", lo, 32'hFFFFFFFF);
    check("divmax_hi", hi, 32'h0);
    $display("txn DIVU ffffffff/1 hi=%h lo=%h", hi, lo);

    // DIVU by zero finishes after one cycle and never raises busy.
    run_op(1'b1, 32'd5, 32'd0, lat, bcyc);
    check("div0_lat", lat, 1);
    check("div0_busy_cycles", bcyc, 0);
    check("div0_hi", hi, 32'd5);
    check("div0_lo", lo, 32'hFFFFFFFF);
    $display("txn DIVU 5/0 lat=%0d hi=%h lo=%h", lat, hi, lo);

    // MULTU 3*4 with a second start at cycle 10, and another start during the DONE cycle.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check("mul34_alu_ctl", {28'b0, alu_ctl}, 32'h2);
    check("mul34_alu_b", alu_b, 32'd4);
    while (lat < 10) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    lat++;
    start = 1'b0;
    check("mul34_busy_mid", {31'b0, busy}, 32'h1);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("mul34_lat", lat, 33);
    check("mul34_hi", hi, 32'h0);
    check("mul34_lo", lo, 32'd12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_busy", {31'b0, busy}, 32'h0);
    check("done_start_done", {31'b0, done}, 32'h0);
    check("done_start_lo_hold", lo, 32'd12);
    $display("txn MULTU 3*4 with ignored starts lo=%h", lo);

    // Abort at cycle 15 of a MULTU must leave done low.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 15) begin
      @(negedge clk);
      lat++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("abort_no_done", dcount, 0);
    $display("txn MULTU 5*5 aborted at cycle 15");

    // abort has priority over start while in IDLE.
    start = 1'b1; abort = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", {31'b0, busy}, 32'h0);
    check("idle_abort_done", {31'b0, done}, 32'h0);
    $display("txn start+abort in IDLE ignored");

    // Asynchronous reset at cycle 20 of a DIVU.
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    check("div_run_alu_ctl", {28'b0, alu_ctl}, 32'h6);
    check("div_run_alu_b", alu_b, 32'd3);
    while (lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", {31'b0, busy}, 32'h0);
    check("arst_done", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn DIVU 1000/3 reset at cycle 20");

    // A new MULTU after the reset.
    run_op(1'b0, 32'd2, 32'd3, lat, bcyc);
    check("mul23_lat", lat, 33);
    check("mul23_hi", hi, 32'h0);
    check("mul23_lo", lo, 32'd6);
    $display("txn MULTU 2*3 hi=%h lo=%h", hi, lo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
